// File: rtl/out_port_pkg.sv
// out_port_pkg: shared types and default sizing for the output-port unit.
//   - out_state_e : output-stage FSM state (StIdle, StSend)
//   - DefaultDataW: default datapath width (matches BusMuxOut)
//   - DefaultDepth: default FIFO depth (power of two, >= 2)
package out_port_pkg;

   localparam int unsigned DefaultDataW = 32;
   localparam int unsigned DefaultDepth = 4;

   typedef enum logic {
      StIdle,
      StSend
   } out_state_e;

endpackage

// File: rtl/out_port_unit_fifo.sv
// sync_fifo: single-clock FIFO feeding the output stage.
//   clk     in   system clock, rising edge
//   clr     in   synchronous active-low reset; discards all entries
//   wr_en   in   write request (ignored when full unless rd_en pops on the same edge)
//   wr_data in   word to append at the tail
//   rd_en   in   pop the head (ignored when empty)
//   rd_data out  combinational head word
//   level   out  occupancy 0..DEPTH (registered)
//   full    out  level == DEPTH
//   empty   out  level == 0
module sync_fifo #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned DEPTH  = 4
) (
   input  logic                     clk,
   input  logic                     clr,
   input  logic                     wr_en,
   input  logic [DATA_W-1:0]        wr_data,
   input  logic                     rd_en,
   output logic [DATA_W-1:0]        rd_data,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     full,
   output logic                     empty
);

   localparam int unsigned PtrW = $clog2(DEPTH);
   localparam int unsigned CntW = PtrW + 1;

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] mem_d [DEPTH];
   logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0]   count_q, count_d;
   logic              do_wr, do_rd;

   assign full    = (count_q == CntW'(DEPTH));
   assign empty   = (count_q == '0);
   assign level   = count_q;
   assign rd_data = mem_q[rd_ptr_q];

   always_comb begin
      do_rd = rd_en && !empty;
      // A pop on the same edge frees the slot, so a full FIFO can still take a write.
      do_wr = wr_en && (!full || do_rd);

      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;

      if (do_wr) begin
         mem_d[wr_ptr_q] = wr_data;
         wr_ptr_d        = wr_ptr_q + PtrW'(1);  // wraps modulo DEPTH
      end
      if (do_rd) begin
         rd_ptr_d = rd_ptr_q + PtrW'(1);
      end
      if (do_wr && !do_rd) begin
         count_d = count_q + CntW'(1);
      end else if (do_rd && !do_wr) begin
         count_d = count_q - CntW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!clr) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: entries are only visible through count_q.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

endmodule

// File: rtl/out_port_unit.sv
// out_port_unit: write-side port of the datapath.
// On Out_rd the word on BusMuxOut is captured into the architectural Out register and
// queued in a FIFO; an output stage drains the FIFO to an external device over a
// valid/ready handshake. A capture into a full FIFO with no simultaneous pop is dropped
// and latches the sticky ovf flag.
//   clk        in   system clock, rising edge
//   clr        in   synchronous active-low reset
//   BusMuxOut  in   datapath bus
//   Out_rd     in   capture strobe from control
//   out_data   out  word presented to the device (registered)
//   out_valid  out  out_data valid (registered)
//   out_ready  in   device accepts the word
//   Out_view   out  architectural Out register
//   full       out  FIFO holds DEPTH words
//   empty      out  FIFO holds no words (output stage excluded)
//   level      out  FIFO occupancy 0..DEPTH
//   ovf        out  sticky drop flag, cleared only by reset
module out_port_unit
   import out_port_pkg::*;
#(
   parameter int unsigned DATA_W = DefaultDataW,
   parameter int unsigned DEPTH  = DefaultDepth
) (
   input  logic                     clk,
   input  logic                     clr,
   input  logic [DATA_W-1:0]        BusMuxOut,
   input  logic                     Out_rd,
   output logic [DATA_W-1:0]        out_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [DATA_W-1:0]        Out_view,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     ovf
);

   out_state_e        state_q, state_d;
   logic [DATA_W-1:0] out_data_q, out_data_d;
   logic [DATA_W-1:0] view_q, view_d;
   logic              ovf_q, ovf_d;

   logic              fifo_wr, fifo_rd;
   logic [DATA_W-1:0] fifo_head;
   logic              fifo_full, fifo_empty;

   sync_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .clr     (clr),
      .wr_en   (fifo_wr),
      .wr_data (BusMuxOut),
      .rd_en   (fifo_rd),
      .rd_data (fifo_head),
      .level   (level),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   // Output stage: load from the FIFO head whenever the stage is free or being emptied.
   always_comb begin
      state_d    = state_q;
      out_data_d = out_data_q;
      fifo_rd    = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (!fifo_empty) begin
               fifo_rd    = 1'b1;
               out_data_d = fifo_head;
               state_d    = StSend;
            end
         end
         StSend: begin
            if (out_ready) begin
               if (!fifo_empty) begin
                  fifo_rd    = 1'b1;
                  out_data_d = fifo_head;
               end else begin
                  state_d = StIdle;
               end
            end
         end
      endcase
   end

   // Capture path: Out_view always updates; the FIFO write only when there is room.
   always_comb begin
      fifo_wr = Out_rd && (!fifo_full || fifo_rd);
      view_d  = Out_rd ? BusMuxOut : view_q;
      ovf_d   = ovf_q || (Out_rd && !fifo_wr);
   end

   always_ff @(posedge clk) begin
      if (!clr) begin
         state_q    <= StIdle;
         out_data_q <= '0;
         view_q     <= '0;
         ovf_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         out_data_q <= out_data_d;
         view_q     <= view_d;
         ovf_q      <= ovf_d;
      end
   end

   assign out_data  = out_data_q;
   assign out_valid = (state_q == StSend);
   assign Out_view  = view_q;
   assign full      = fifo_full;
   assign empty     = fifo_empty;
   assign ovf       = ovf_q;

endmodule

// File: tb/tb_out_port_unit.sv
module tb_out_port_unit;

   localparam int unsigned DW = 32;
   localparam int unsigned DP = 4;

   logic                 clk = 1'b0;
   logic                 clr;
   logic [DW-1:0]        BusMuxOut;
   logic                 Out_rd;
   logic [DW-1:0]        out_data;
   logic                 out_valid;
   logic                 out_ready;
   logic [DW-1:0]        Out_view;
   logic                 full;
   logic                 empty;
   logic [$clog2(DP):0]  level;
   logic                 ovf;

   int nvec = 0;
   int nerr = 0;

   always #5 clk = ~clk;

   out_port_unit #(
      .DATA_W (DW),
      .DEPTH  (DP)
   ) dut (
      .clk       (clk),
      .clr       (clr),
      .BusMuxOut (BusMuxOut),
      .Out_rd    (Out_rd),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .Out_view  (Out_view),
      .full      (full),
      .empty     (empty),
      .level     (level),
      .ovf       (ovf)
   );

   // Reference model: words waiting in the FIFO, plus a delivery scoreboard of every
   // accepted word not yet handed to the device (in capture order).
   logic [DW-1:0] mq[$];
   logic [DW-1:0] sb[$];
   bit            m_valid;
   logic [DW-1:0] m_data;
   logic [DW-1:0] m_view;
   bit            m_ovf;
   bit            m_hs;
   logic [DW-1:0] m_hs_word;
   // What the DUT showed on the last step
   bit            hs_seen;
   logic [DW-1:0] hs_word;

   task automatic do_reset(input bit rd, input logic [DW-1:0] d, input bit rdy);
      clr = 1'b0; Out_rd = rd; BusMuxOut = d; out_ready = rdy;
      @(posedge clk); #1;
      clr = 1'b1; Out_rd = 1'b0; out_ready = 1'b0;
      mq.delete(); sb.delete();
      m_valid = 0; m_data = '0; m_view = '0; m_ovf = 0;
   endtask

   // Apply one cycle of inputs, advance the model, and sample #1 after the edge.
   task automatic step(input bit rd, input logic [DW-1:0] d, input bit rdy);
      bit pop, accept;
      int n;
      Out_rd = rd; BusMuxOut = d; out_ready = rdy;
      #1;
      hs_seen = out_valid && rdy;
      hs_word = out_data;
      n    = mq.size();
      m_hs = m_valid && rdy;
      if (m_hs) m_hs_word = (sb.size() > 0) ? sb.pop_front() : 'x;
      pop    = (n > 0) && (!m_valid || rdy);
      accept = rd && ((n < int'(DP)) || pop);
      if (rd) m_view = d;
      if (rd && !accept) m_ovf = 1;
      if (pop) begin
         m_data  = mq.pop_front();
         m_valid = 1;
      end else if (m_hs) begin
         m_valid = 0;
      end
      if (accept) begin
         mq.push_back(d);
         sb.push_back(d);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      do_reset(1'b1, 32'hFFFF_FFFF, 1'b1);
      nvec++; if (Out_view !== '0) begin nerr++; $display("FAIL reset_view: got %h want 0", Out_view); end
      nvec++; if (out_data !== '0) begin nerr++; $display("FAIL reset_data: got %h want 0", out_data); end
      nvec++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL reset_valid: got %b want 0", out_valid); end
      nvec++; if (level !== '0) begin nerr++; $display("FAIL reset_level: got %0d want 0", level); end
      nvec++; if (empty !== 1'b1) begin nerr++; $display("FAIL reset_empty: got %b want 1", empty); end
      nvec++; if (full !== 1'b0) begin nerr++; $display("FAIL reset_full: got %b want 0", full); end
      nvec++; if (ovf !== 1'b0) begin nerr++; $display("FAIL reset_ovf: got %b want 0", ovf); end
   endtask

   task automatic test_single();
      do_reset(0, '0, 0);
      step(1, 32'd39, 1);
      nvec++; if (Out_view !== 32'd39) begin nerr++; $display("FAIL single_view: got %0d want 39", Out_view); end
      nvec++; if (out_valid !== 1'b0 || empty !== 1'b0) begin
         nerr++; $display("FAIL single_k: got valid=%b empty=%b want valid=0 empty=0", out_valid, empty);
      end
      step(0, '0, 1);
      nvec++; if (out_valid !== 1'b1 || out_data !== 32'd39) begin
         nerr++; $display("FAIL single_k1: got valid=%b data=%0d want valid=1 data=39", out_valid, out_data);
      end
      step(0, '0, 1);
      nvec++; if (!hs_seen || hs_word !== 32'd39) begin
         nerr++; $display("FAIL single_hs: got hs=%b word=%0d want hs=1 word=39", hs_seen, hs_word);
      end
      nvec++; if (out_valid !== 1'b0 || empty !== 1'b1) begin
         nerr++; $display("FAIL single_after: got valid=%b empty=%b want valid=0 empty=1", out_valid, empty);
      end
   endtask

   task automatic test_fill_drop();
      logic [DW-1:0] exp_w[5];
      int nhs;
      exp_w[0] = 32'h11; exp_w[1] = 32'h22; exp_w[2] = 32'h33; exp_w[3] = 32'h44; exp_w[4] = 32'h55;
      do_reset(0, '0, 0);
      for (int i = 0; i < 5; i++) step(1, exp_w[i], 0);
      nvec++; if (out_valid !== 1'b1 || out_data !== 32'h11) begin
         nerr++; $display("FAIL fill_stage: got valid=%b data=%h want valid=1 data=11", out_valid, out_data);
      end
      nvec++; if (level !== 3'd4 || full !== 1'b1 || ovf !== 1'b0) begin
         nerr++; $display("FAIL fill_state: got level=%0d full=%b ovf=%b want 4 1 0", level, full, ovf);
      end
      step(1, 32'h66, 0);
      nvec++; if (ovf !== 1'b1 || Out_view !== 32'h66 || level !== 3'd4) begin
         nerr++; $display("FAIL drop: got ovf=%b view=%h level=%0d want 1 66 4", ovf, Out_view, level);
      end
      nhs = 0;
      for (int c = 0; c < 10; c++) begin
         step(0, '0, 1);
         if (hs_seen) begin
            nvec++;
            if (nhs >= 5) begin
               nerr++; $display("FAIL drain_extra: got word %h want none", hs_word);
            end else if (hs_word !== exp_w[nhs]) begin
               nerr++; $display("FAIL drain_order: got %h want %h", hs_word, exp_w[nhs]);
            end
            nhs++;
         end
      end
      nvec++; if (nhs != 5) begin nerr++; $display("FAIL drain_count: got %0d want 5", nhs); end
   endtask

   task automatic test_full_push();
      do_reset(0, '0, 0);
      for (int i = 1; i <= 5; i++) step(1, DW'(i * 32'h11), 0);
      step(1, 32'h77, 1);
      nvec++; if (level !== 3'd4 || full !== 1'b1 || ovf !== 1'b0) begin
         nerr++; $display("FAIL full_push: got level=%0d full=%b ovf=%b want 4 1 0", level, full, ovf);
      end
      nvec++; if (!hs_seen || hs_word !== 32'h11 || out_data !== 32'h22 || Out_view !== 32'h77) begin
         nerr++; $display("FAIL full_push_data: got hs=%b word=%h data=%h view=%h want 1 11 22 77",
                          hs_seen, hs_word, out_data, Out_view);
      end
   endtask

   task automatic test_back_to_back();
      logic [DW-1:0] w[8];
      int nhs, nvalid;
      bit seen_valid, gap;
      nhs = 0; nvalid = 0; seen_valid = 0; gap = 0;
      do_reset(0, '0, 0);
      foreach (w[i]) w[i] = $urandom;
      for (int c = 0; c < 12; c++) begin
         step(c < 8, w[c & 7], 1);
         if (hs_seen) begin
            nvec++;
            if (nhs >= 8) begin
               nerr++; $display("FAIL b2b_extra: got word %h want none", hs_word);
            end else if (hs_word !== w[nhs]) begin
               nerr++; $display("FAIL b2b_order: got %h want %h", hs_word, w[nhs]);
            end
            nhs++;
         end
         if (out_valid) begin
            seen_valid = 1; nvalid++;
         end else if (seen_valid && nhs < 8) begin
            gap = 1;
         end
      end
      nvec++; if (nhs != 8 || nvalid != 8 || gap) begin
         nerr++; $display("FAIL b2b_rate: got hs=%0d valid_cycles=%0d gap=%b want 8 8 0", nhs, nvalid, gap);
      end
   endtask

   task automatic test_backpressure();
      bit rd, rdy, held;
      logic [DW-1:0] d, held_data;
      do_reset(0, '0, 0);
      for (int c = 0; c < 300 + DP + 4; c++) begin
         if (c < 300) begin
            rd  = ($urandom_range(0, 2) != 0);
            rdy = $urandom_range(0, 1);
         end else begin
            rd = 0; rdy = 1;
         end
         d         = $urandom;
         held      = out_valid && !rdy;
         held_data = out_data;
         step(rd, d, rdy);
         nvec++;
         if (hs_seen !== m_hs || (hs_seen && hs_word !== m_hs_word)) begin
            nerr++; $display("FAIL bp_handshake: cycle %0d got hs=%b word=%h want hs=%b word=%h",
                             c, hs_seen, hs_word, m_hs, m_hs_word);
         end
         if (held) begin
            nvec++;
            if (out_valid !== 1'b1 || out_data !== held_data) begin
               nerr++; $display("FAIL bp_stable: cycle %0d got valid=%b data=%h want 1 %h",
                                c, out_valid, out_data, held_data);
            end
         end
         nvec++;
         if (out_valid !== m_valid || (m_valid && out_data !== m_data)) begin
            nerr++; $display("FAIL bp_stage: cycle %0d got valid=%b data=%h want %b %h",
                             c, out_valid, out_data, m_valid, m_data);
         end
         nvec++;
         if (int'(level) != mq.size() || full !== (mq.size() == int'(DP)) ||
             empty !== (mq.size() == 0)) begin
            nerr++; $display("FAIL bp_level: cycle %0d got level=%0d full=%b empty=%b want level=%0d",
                             c, level, full, empty, mq.size());
         end
         nvec++;
         if (ovf !== m_ovf || Out_view !== m_view) begin
            nerr++; $display("FAIL bp_view: cycle %0d got ovf=%b view=%h want %b %h",
                             c, ovf, Out_view, m_ovf, m_view);
         end
      end
      nvec++; if (sb.size() != 0 || out_valid !== 1'b0) begin
         nerr++; $display("FAIL bp_drained: got pending=%0d valid=%b want 0 0", sb.size(), out_valid);
      end
   endtask

   task automatic test_reset_midstream();
      do_reset(0, '0, 0);
      for (int i = 0; i < 4; i++) step(1, $urandom, 0);
      nvec++; if (level !== 3'd3 || out_valid !== 1'b1) begin
         nerr++; $display("FAIL mid_pre: got level=%0d valid=%b want 3 1", level, out_valid);
      end
      do_reset(1'b1, 32'hDEAD_BEEF, 1'b1);
      nvec++;
      if (Out_view !== '0 || out_data !== '0 || out_valid !== 1'b0 || level !== '0 ||
          empty !== 1'b1 || full !== 1'b0 || ovf !== 1'b0) begin
         nerr++; $display("FAIL mid_reset: got view=%h data=%h valid=%b level=%0d empty=%b full=%b ovf=%b want all reset",
                          Out_view, out_data, out_valid, level, empty, full, ovf);
      end
      for (int c = 0; c < 5; c++) begin
         step(0, '0, 1);
         nvec++;
         if (hs_seen || out_valid !== 1'b0 || empty !== 1'b1) begin
            nerr++; $display("FAIL mid_stale: cycle %0d got hs=%b valid=%b empty=%b want 0 0 1",
                             c, hs_seen, out_valid, empty);
         end
      end
   endtask

   initial begin
      clr = 1'b0; Out_rd = 1'b0; out_ready = 1'b0; BusMuxOut = '0;
      test_reset();
      test_single();
      test_fill_drop();
      test_full_push();
      test_back_to_back();
      test_backpressure();
      test_reset_midstream();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
